// File: rtl/coin_acceptor.sv
// coin_acceptor
// Front-end for the vending machine's coin mechanism. It synchronises and
// debounces the raw optical coin-sense line, then measures how many cycles a
// coin blocks the beam to classify its denomination. It sits directly upstream
// of the vending controller.
//   - Valid coins load a code on `coin` and raise one `drop_coin` strobe.
//   - Invalid coins, coins seen while disabled, and jams are diverted with a
//     `coin_return` strobe.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   coin_sense   raw asynchronous sensor, high while a coin blocks the beam
//   accept_en    controller is accepting money; sampled at the coin's rising edge
//   coin[1:0]    denomination code: 0=10, 1=20, 3=50, 2=100
//   drop_coin    STROBE_LEN-cycle strobe for an accepted coin
//   coin_return  STROBE_LEN-cycle strobe for a coin sent to the return chute
//   jam          sensor blocked longer than the counter range
//   busy         FSM is not idle
//
// Optional build macro COIN_AUDIT_EN adds these saturating 16-bit counters,
// which only reset clears:
//   audit_cnt10 / audit_cnt20 / audit_cnt50 / audit_cnt100  accepted coins
//   audit_rej                                               returned coins
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a fresh debounced rise
// MEASURE  | coin blocking the beam, counting its width
// CLASSIFY | one cycle to decide between accept and reject
// ACCEPT   | drop_coin strobe
// REJECT   | coin_return strobe
// JAM      | width counter saturated; wait for the sensor to clear
// LOCKOUT  | GAP_CYCLES dead time after any strobe

module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8,
    parameter int STROBE_LEN = 2,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_sense,
    input  logic       accept_en,
    output logic [1:0] coin,
    output logic       drop_coin,
    output logic       coin_return,
    output logic       jam,
    output logic       busy
`ifdef COIN_AUDIT_EN
    ,
    output logic [15:0] audit_cnt10,
    output logic [15:0] audit_cnt20,
    output logic [15:0] audit_cnt50,
    output logic [15:0] audit_cnt100,
    output logic [15:0] audit_rej
`endif
);

    localparam int TMR_MAX = (GAP_CYCLES > STROBE_LEN) ? GAP_CYCLES : STROBE_LEN;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int DB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] CNT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEASURE,
        S_CLASSIFY,
        S_ACCEPT,
        S_REJECT,
        S_JAM,
        S_LOCKOUT
    } state_t;

    state_t state, state_next;

    logic            sync1, sync2;
    logic [1:0]      sync_fill;
    logic            sense_db, db_prev, armed;
    logic [DB_W-1:0] db_cnt;
    logic            db_rise;

    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] tmr;
    logic             en_lat;

    logic       cnt_start, cnt_inc, tmr_ld_strobe, tmr_ld_gap, coin_ld;
    logic       in_window;
    logic [1:0] win_code;

    // Synchroniser and debouncer. Both edges see the same delay, so the width
    // seen on sense_db equals the raw width.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync_fill <= 2'b00;
            sense_db <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
            armed    <= 1'b0;
        end else begin
            sync1     <= coin_sense;
            sync2     <= sync1;
            sync_fill <= {sync_fill[0], 1'b1};
            db_prev   <= sense_db;
            if (sync2 != sense_db) begin
                if (db_cnt == DB_W'(DEB_CYCLES - 1)) begin
                    sense_db <= sync2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
            // A coin still in the beam across a reset must not be measured:
            // rises count only once the line has been seen clear.
            if (sync_fill[1] && !sync2)
                armed <= 1'b1;
        end
    end

    assign db_rise = sense_db & ~db_prev & armed;

    // Width windows: 10:[8,15] 20:[16,31] 50:[32,63] 100:[64,127]
    always_comb begin
        in_window = 1'b1;
        win_code  = 2'd0;
        if (cnt < CNT_W'(8))
            in_window = 1'b0;
        else if (cnt < CNT_W'(16))
            win_code = 2'd0;
        else if (cnt < CNT_W'(32))
            win_code = 2'd1;
        else if (cnt < CNT_W'(64))
            win_code = 2'd3;
        else if (cnt < CNT_W'(128))
            win_code = 2'd2;
        else
            in_window = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        cnt_start     = 1'b0;
        cnt_inc       = 1'b0;
        tmr_ld_strobe = 1'b0;
        tmr_ld_gap    = 1'b0;
        coin_ld       = 1'b0;
        drop_coin     = 1'b0;
        coin_return   = 1'b0;
        jam           = 1'b0;
        busy          = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (db_rise) begin
                    state_next = S_MEASURE;
                    cnt_start  = 1'b1;
                end
            end
            S_MEASURE: begin
                if (!sense_db) begin
                    state_next = S_CLASSIFY;
                    // Loading coin on the fall puts the code out one cycle
                    // ahead of drop_coin.
                    coin_ld    = en_lat & in_window;
                end else begin
                    cnt_inc = 1'b1;
                    if (cnt == CNT_PRE)
                        state_next = S_JAM;
                end
            end
            S_CLASSIFY: begin
                tmr_ld_strobe = 1'b1;
                state_next    = (en_lat && in_window) ? S_ACCEPT : S_REJECT;
            end
            S_ACCEPT: begin
                drop_coin = 1'b1;
                if (tmr == '0) begin
                    state_next = S_LOCKOUT;
                    tmr_ld_gap = 1'b1;
                end
            end
            S_REJECT: begin
                coin_return = 1'b1;
                if (tmr == '0) begin
                    state_next = S_LOCKOUT;
                    tmr_ld_gap = 1'b1;
                end
            end
            S_JAM: begin
                jam = sense_db;
                if (!sense_db) begin
                    state_next    = S_REJECT;
                    tmr_ld_strobe = 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (tmr == '0)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            tmr    <= '0;
            en_lat <= 1'b0;
            coin   <= 2'd0;
        end else begin
            if (cnt_start) begin
                cnt    <= CNT_W'(1);
                en_lat <= accept_en;
            end else if (cnt_inc && cnt != CNT_SAT) begin
                cnt <= cnt + 1'b1;
            end

            if (tmr_ld_strobe)
                tmr <= TMR_W'(STROBE_LEN - 1);
            else if (tmr_ld_gap)
                tmr <= TMR_W'(GAP_CYCLES - 1);
            else if (tmr != '0)
                tmr <= tmr - 1'b1;

            if (coin_ld)
                coin <= win_code;
        end
    end

`ifdef COIN_AUDIT_EN
    logic drop_q, ret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q       <= 1'b0;
            ret_q        <= 1'b0;
            audit_cnt10  <= '0;
            audit_cnt20  <= '0;
            audit_cnt50  <= '0;
            audit_cnt100 <= '0;
            audit_rej    <= '0;
        end else begin
            drop_q <= drop_coin;
            ret_q  <= coin_return;
            if (drop_coin && !drop_q) begin
                case (coin)
                    2'd0:    if (audit_cnt10  != 16'hFFFF) audit_cnt10  <= audit_cnt10  + 1'b1;
                    2'd1:    if (audit_cnt20  != 16'hFFFF) audit_cnt20  <= audit_cnt20  + 1'b1;
                    2'd3:    if (audit_cnt50  != 16'hFFFF) audit_cnt50  <= audit_cnt50  + 1'b1;
                    default: if (audit_cnt100 != 16'hFFFF) audit_cnt100 <= audit_cnt100 + 1'b1;
                endcase
            end
            if (coin_return && !ret_q && audit_rej != 16'hFFFF)
                audit_rej <= audit_rej + 1'b1;
        end
    end
`endif

endmodule
